// File: rtl/button_events.sv
`default_nettype none
// button_events: per-channel gesture decoder turning debounced button levels
// into single-cycle press / release / long-press / auto-repeat pulses.
module button_events #(
   parameter int N           = 5,
   parameter int HOLD_TIME   = 8,
   parameter int REPEAT_TIME = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [N-1:0] i_level,
   output logic [N-1:0] o_press,
   output logic [N-1:0] o_release,
   output logic [N-1:0] o_long_press,
   output logic [N-1:0] o_repeat,
   output logic [N-1:0] o_held
);

   localparam int MAX_T = (HOLD_TIME > REPEAT_TIME) ? HOLD_TIME : REPEAT_TIME;
   localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

   localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_TIME - 1);
   localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TIME - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_LONG    = 2'd2
   } state_t;

   generate
      for (genvar g = 0; g < N; g++) begin : g_ch
         state_t        r_state;
         logic [CW-1:0] r_cnt;
         logic          r_prev;
         logic          r_press;
         logic          r_release;
         logic          r_long;
         logic          r_repeat;

         always_ff @(posedge clock) begin
            if (!reset) begin
               r_state   <= ST_IDLE;
               r_cnt     <= '0;
               r_prev    <= 1'b0;
               r_press   <= 1'b0;
               r_release <= 1'b0;
               r_long    <= 1'b0;
               r_repeat  <= 1'b0;
            end else begin
               r_prev    <= i_level[g];
               r_press   <= 1'b0;
               r_release <= 1'b0;
               r_long    <= 1'b0;
               r_repeat  <= 1'b0;
               case (r_state)
                  ST_IDLE: begin
                     if (i_level[g] && !r_prev) begin
                        r_press <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_PRESSED;
                     end
                  end
                  // Release is tested first so it wins over a due long-press/repeat.
                  ST_PRESSED: begin
                     if (!i_level[g]) begin
                        r_release <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_IDLE;
                     end else if (r_cnt == HOLD_LAST) begin
                        r_long  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_LONG;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
                  ST_LONG: begin
                     if (!i_level[g]) begin
                        r_release <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_IDLE;
                     end else if (r_cnt == REPEAT_LAST) begin
                        r_repeat <= 1'b1;
                        r_cnt    <= '0;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
                  default: begin
                     r_cnt   <= '0;
                     r_state <= ST_IDLE;
                  end
               endcase
            end
         end

         assign o_press[g]      = r_press;
         assign o_release[g]    = r_release;
         assign o_long_press[g] = r_long;
         assign o_repeat[g]     = r_repeat;
         assign o_held[g]       = (r_state == ST_PRESSED) || (r_state == ST_LONG);
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_events.sv
`default_nettype none
// tb_button_events: directed-vector bench for button_events (N=5, HOLD=8, REPEAT=4).
module tb_button_events;

   logic       clk;
   logic       rst_n;
   logic [4:0] lvl;
   logic [4:0] w_press, w_release, w_long, w_repeat, w_held;

   int n_tests = 0;
   int n_fail  = 0;

   button_events #(.N(5), .HOLD_TIME(8), .REPEAT_TIME(4)) u_dut (
      .clock        (clk),
      .reset        (rst_n),
      .i_level      (lvl),
      .o_press      (w_press),
      .o_release    (w_release),
      .o_long_press (w_long),
      .o_repeat     (w_repeat),
      .o_held       (w_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] m(input bit c, input int ch);
      return c ? 5'(1 << ch) : 5'd0;
   endfunction

   task automatic chk_cycle(input string name, input int t,
                            input logic [4:0] ep, input logic [4:0] er,
                            input logic [4:0] el, input logic [4:0] erp,
                            input logic [4:0] eh);
      check($sformatf("%s t=%0d press", name, t),   w_press,   ep);
      check($sformatf("%s t=%0d release", name, t), w_release, er);
      check($sformatf("%s t=%0d long", name, t),    w_long,    el);
      check($sformatf("%s t=%0d repeat", name, t),  w_repeat,  erp);
      check($sformatf("%s t=%0d held", name, t),    w_held,    eh);
   endtask

   task automatic idle_gap();
      lvl = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      chk_cycle("gap", 0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      lvl   = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      chk_cycle("reset", 0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
      rst_n = 1'b1;
      idle_gap();

      // Long hold on ch0: press@0, long@8, repeat@12,16, release@18, none@20
      lvl = 5'b00001;
      for (int t = 0; t <= 20; t++) begin
         @(posedge clk); #1;
         chk_cycle("long_hold", t, m(t == 0, 0), m(t == 18, 0), m(t == 8, 0),
                   m(t == 12 || t == 16, 0), m(t < 18, 0));
         if (t == 17) lvl = 5'd0;
      end
      idle_gap();

      // Short press on ch2: high t0..3, release@4, no long-press
      lvl = 5'b00100;
      for (int t = 0; t <= 10; t++) begin
         @(posedge clk); #1;
         chk_cycle("short", t, m(t == 0, 2), m(t == 4, 2), 5'd0, 5'd0, m(t < 4, 2));
         if (t == 3) lvl = 5'd0;
      end
      idle_gap();

      // Second press on ch2: counter restarts, long-press exactly 8 edges later
      lvl = 5'b00100;
      for (int t = 0; t <= 9; t++) begin
         @(posedge clk); #1;
         chk_cycle("short_again", t, m(t == 0, 2), m(t == 9, 2), m(t == 8, 2),
                   5'd0, m(t < 9, 2));
         if (t == 8) lvl = 5'd0;
      end
      idle_gap();

      // Release collides with due long-press on ch1
      lvl = 5'b00010;
      for (int t = 0; t <= 10; t++) begin
         @(posedge clk); #1;
         chk_cycle("rel_vs_long", t, m(t == 0, 1), m(t == 8, 1), 5'd0, 5'd0, m(t < 8, 1));
         if (t == 7) lvl = 5'd0;
      end
      idle_gap();

      // Release collides with due repeat on ch1
      lvl = 5'b00010;
      for (int t = 0; t <= 14; t++) begin
         @(posedge clk); #1;
         chk_cycle("rel_vs_rep", t, m(t == 0, 1), m(t == 12, 1), m(t == 8, 1),
                   5'd0, m(t < 12, 1));
         if (t == 11) lvl = 5'd0;
      end
      idle_gap();

      // Reset during LONG on ch3: reset low at edges 10,11, press again @12
      lvl = 5'b01000;
      for (int t = 0; t <= 26; t++) begin
         @(posedge clk); #1;
         chk_cycle("reset_long", t, m(t == 0 || t == 12, 3), m(t == 26, 3),
                   m(t == 8 || t == 20, 3), m(t == 24, 3),
                   m(t < 10 || (t >= 12 && t < 26), 3));
         if (t == 9)  rst_n = 1'b0;
         if (t == 11) rst_n = 1'b1;
         if (t == 25) lvl = 5'd0;
      end
      idle_gap();

      // Independence: ch0 and ch4 pressed together, ch4 released at 3, ch0 at 10
      lvl = 5'b10001;
      for (int t = 0; t <= 12; t++) begin
         @(posedge clk); #1;
         chk_cycle("indep", t, m(t == 0, 0) | m(t == 0, 4),
                   m(t == 3, 4) | m(t == 10, 0), m(t == 8, 0), 5'd0,
                   m(t < 10, 0) | m(t < 3, 4));
         if (t == 2) lvl[4] = 1'b0;
         if (t == 9) lvl = 5'd0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/button_events.md
# button_events

Per-button gesture decoder that consumes the debounced button levels produced by the input-conditioning stage and turns them into single-cycle event pulses: press, release, long-press and auto-repeat. It sits between the debouncer and the front-panel control logic (run/stop, threshold adjust, display paging) of the muon-lifetime controller. Each button channel is independent and runs its own small state machine and hold counter.

## Interface
- `N`, 5: number of button channels.
- `HOLD_TIME`, 8: cycles from press to long-press event; must be ≥ 2 (board build uses 50_000_000).
- `REPEAT_TIME`, 4: cycles between auto-repeat pulses after long-press; must be ≥ 1 (board build uses 10_000_000).
- `clock`  in  1  system clock, 100 MHz, all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset; 0 = reset.
- `level`  in  N  debounced button levels, 1 = pressed; synchronous to `clock`.
- `press`  out  N  one-cycle pulse per channel on a press.
- `release`  out  N  one-cycle pulse per channel on a release.
- `long_press`  out  N  one-cycle pulse when a press has been held `HOLD_TIME` cycles.
- `repeat`  out  N  one-cycle pulse every `REPEAT_TIME` cycles after long-press while still held.
- `held`  out  N  level, 1 while the channel is in PRESSED or LONG.

## Operation
- Per channel i: registers `prev[i]`, state (IDLE, PRESSED, LONG), counter `cnt[i]` of width $clog2(max(HOLD_TIME, REPEAT_TIME)).
- All outputs registered; every output and `prev`, `cnt` reset to 0, state to IDLE.
- Pulse outputs default to 0 every cycle. At most one of press/release/long_press/repeat is high per channel per cycle.
- IDLE: edge with `level[i]`=1 and `prev[i]`=0 -> `press[i]`=1, `cnt`=0, go PRESSED.
- PRESSED, `level[i]`=1: if `cnt`==HOLD_TIME-1 -> `long_press[i]`=1, `cnt`=0, go LONG; else `cnt`+1.
- LONG, `level[i]`=1: if `cnt`==REPEAT_TIME-1 -> `repeat[i]`=1, `cnt`=0; else `cnt`+1.
- PRESSED or LONG, `level[i]`=0 -> `release[i]`=1, `cnt`=0, go IDLE. Release wins over a long_press or repeat due on the same edge.
- `held[i]` = 1 exactly when the registered state is PRESSED or LONG.
- `prev[i]` <= `level[i]` every non-reset edge.
- Counter never wraps. It is cleared on every state change and compared only against its terminal value.
- Channels are fully independent. Simultaneous events on different channels all appear in the same cycle.

## Timing
- Let E0 be the first edge sampling `level[i]`=1 after it was 0.
- `press[i]` is high for the cycle after E0. Latency is 1 cycle from the sampled level.
- `long_press[i]` is registered at edge E0+HOLD_TIME if level stays 1 through that edge.
- `repeat[i]` is registered at edges E0+HOLD_TIME+k·REPEAT_TIME, k ≥ 1.
- `release[i]` is registered at the first edge sampling `level[i]`=0. `held[i]` falls on the same edge.
- Reset asserted at any point: on that edge all pulses and `held` go 0, state goes IDLE, `prev` goes 0. A pending long-press or repeat is discarded.
- A button still high when reset deasserts yields `press` registered at the first non-reset edge.

## Test plan
- Long hold, HOLD_TIME=8, REPEAT_TIME=4: `level[0]` rises, sampled at edge 10, falls, sampled at 28 -> press@10, long_press@18, repeat@22 and @26, release@28, no repeat@30, `held[0]` high over edges 10–27.
- Short press: `level[2]` high over edges 10–13, low at 14 -> press@10, release@14, no long_press, `cnt` back to 0.
- Release collision: `level[1]` high from edge 10, low sampled at edge 18 -> release@18, long_press never asserted.
- Repeat collision: release sampled at edge 22 in LONG -> release@22, no repeat@22.
- Reset mid-LONG: `reset`=0 at edge 20 for 2 edges, `level[3]` held high -> all outputs 0 at edge 20, press at first edge after reset returns to 1, long_press 8 edges later.
- Independence: channels 0 and 4 pressed on the same edge, channel 4 released 3 edges later -> both press pulses coincide, channel 0 long_press timing unaffected, channel 4 release only.
